mmio_mailbox: RTL and testbench

//  Memory-mapped responder on the CPU data bus for the host mailbox window (default 0x0200_0000).

---
 rtl/mailbox_pkg.sv | 17 +
 rtl/mailbox_fifo.sv | 68 ++++++
 rtl/mmio_mailbox.sv | 148 ++++++++++++++
 tb/tb_mmio_mailbox.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mailbox_pkg.sv
// Shared definitions for the host mailbox window.
// Contents: the FSM state type, the default window base address,
// and the default word indices for the stream and done words.
package mailbox_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } mb_state_e;

  localparam logic [31:0] MB_BASE_ADDR  = 32'h0200_0000;
  localparam int unsigned MB_STREAM_IDX = 2;
  localparam int unsigned MB_DONE_IDX   = 3;

endpackage

// File: rtl/mailbox_fifo.sv
// Synchronous FIFO that carries CPU stream stores to the host.
// Ports: clk; reset (synchronous, active low); push/push_data; pop;
//   full, empty, head (oldest entry, valid when !empty).
// A push while full is accepted only when a pop happens in the same cycle.
module mailbox_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE  = 1;
  localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mmio_mailbox.sv
// Host mailbox window on the CPU data bus.
// Host preloads words through Ext_* while the CPU is held; the CPU loads
// them (combinational read), stores results, streams STREAM_IDX stores
// through a FIFO, and a nonzero store to DONE_IDX raises cpu_done.
// Ports: clk, reset (sync, active low), cpu_run, Ext_MemWrite/Ext_DataAdr/
//   Ext_WriteData, MemWrite/DataAdr/WriteData, mb_hit/mb_rdata,
//   stream_valid/stream_data/stream_ready, cpu_done, overflow, mb_state,
//   run_cycles.
// Macro MAILBOX_CYCLE_COUNT_EN enables the RUN cycle counter; otherwise
// run_cycles is tied to zero.
module mmio_mailbox
  import mailbox_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = MB_BASE_ADDR,
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned STREAM_IDX = MB_STREAM_IDX,
  parameter int unsigned DONE_IDX   = MB_DONE_IDX,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_run,
  input  logic        Ext_MemWrite,
  input  logic [31:0] Ext_DataAdr,
  input  logic [31:0] Ext_WriteData,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic        mb_hit,
  output logic [31:0] mb_rdata,
  output logic        stream_valid,
  output logic [31:0] stream_data,
  input  logic        stream_ready,
  output logic        cpu_done,
  output logic        overflow,
  output logic [1:0]  mb_state,
  output logic [31:0] run_cycles
);

  localparam int unsigned IW = $clog2(NUM_REGS);

  mb_state_e   state_q, state_d;
  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];
  logic        cpu_done_q, cpu_done_d;
  logic        overflow_q, overflow_d;

  logic [29:0]   cpu_off, ext_off;
  logic          cpu_hit, ext_hit;
  logic [IW-1:0] cpu_idx, ext_idx;
  logic          host_wr, cpu_wr, stream_push, done_store;
  logic          fifo_full, fifo_empty;

  // Word offset from the base; a negative offset wraps to a large value and misses.
  assign cpu_off = DataAdr[31:2] - BASE_ADDR[31:2];
  assign ext_off = Ext_DataAdr[31:2] - BASE_ADDR[31:2];
  assign cpu_hit = (cpu_off < 30'(NUM_REGS)) && (DataAdr[1:0] == 2'b00);
  assign ext_hit = (ext_off < 30'(NUM_REGS)) && (Ext_DataAdr[1:0] == 2'b00);
  assign cpu_idx = cpu_off[IW-1:0];
  assign ext_idx = ext_off[IW-1:0];

  assign host_wr     = ((state_q == ST_IDLE) || (state_q == ST_LOAD)) && !cpu_run
                       && Ext_MemWrite && ext_hit;
  assign cpu_wr      = (state_q == ST_RUN) && MemWrite && cpu_hit;
  assign stream_push = cpu_wr && (cpu_idx == IW'(STREAM_IDX));
  assign done_store  = cpu_wr && (cpu_idx == IW'(DONE_IDX)) && (WriteData != '0);

  assign mb_hit   = cpu_hit;
  assign mb_rdata = cpu_hit ? regs_q[cpu_idx] : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cpu_run)           state_d = ST_RUN;
        else if (Ext_MemWrite) state_d = ST_LOAD;
      end
      ST_LOAD: if (cpu_run)    state_d = ST_RUN;
      ST_RUN:  if (done_store) state_d = ST_DONE;
      ST_DONE: if (!cpu_run)   state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (host_wr) regs_d[ext_idx] = Ext_WriteData;
    if (cpu_wr)  regs_d[cpu_idx] = WriteData;
    cpu_done_d = (state_d == ST_DONE);
    // A push into a full FIFO survives only if the host pops in the same cycle.
    overflow_d = overflow_q | (stream_push & fifo_full & ~stream_ready);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cpu_done_q <= 1'b0;
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cpu_done_q <= cpu_done_d;
      overflow_q <= overflow_d;
      regs_q     <= regs_d;
    end
  end

  mailbox_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (stream_push),
    .push_data (WriteData),
    .pop       (stream_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (stream_data)
  );

  assign stream_valid = ~fifo_empty;
  assign cpu_done     = cpu_done_q;
  assign overflow     = overflow_q;
  assign mb_state     = state_q;

`ifdef MAILBOX_CYCLE_COUNT_EN
  logic [31:0] run_cycles_q, run_cycles_d;

  always_comb begin
    run_cycles_d = run_cycles_q;
    if (((state_q == ST_IDLE) || (state_q == ST_LOAD)) && (state_d == ST_RUN))
      run_cycles_d = '0;
    else if ((state_q == ST_RUN) && (run_cycles_q != '1))
      run_cycles_d = run_cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) run_cycles_q <= '0;
    else        run_cycles_q <= run_cycles_d;
  end

  assign run_cycles = run_cycles_q;
`else
  assign run_cycles = '0;
`endif

endmodule

// File: tb/tb_mmio_mailbox.sv
module tb_mmio_mailbox;

  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam int NR   = 4;
  localparam int SIDX = 2;
  localparam int DIDX = 3;
  localparam int FD   = 16;
`ifdef MAILBOX_CYCLE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, cpu_run, Ext_MemWrite, MemWrite, stream_ready;
  logic [31:0] Ext_DataAdr, Ext_WriteData, DataAdr, WriteData;
  logic        mb_hit, stream_valid, cpu_done, overflow;
  logic [31:0] mb_rdata, stream_data, run_cycles;
  logic [1:0]  mb_state;

  always #5 clk = ~clk;

  mmio_mailbox #(
    .BASE_ADDR  (BASE),
    .NUM_REGS   (NR),
    .STREAM_IDX (SIDX),
    .DONE_IDX   (DIDX),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_run       (cpu_run),
    .Ext_MemWrite  (Ext_MemWrite),
    .Ext_DataAdr   (Ext_DataAdr),
    .Ext_WriteData (Ext_WriteData),
    .MemWrite      (MemWrite),
    .DataAdr       (DataAdr),
    .WriteData     (WriteData),
    .mb_hit        (mb_hit),
    .mb_rdata      (mb_rdata),
    .stream_valid  (stream_valid),
    .stream_data   (stream_data),
    .stream_ready  (stream_ready),
    .cpu_done      (cpu_done),
    .overflow      (overflow),
    .mb_state      (mb_state),
    .run_cycles    (run_cycles)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mailbox words, stream queue, sticky overflow, state number, RUN count.
  int          m_state = 0;
  logic [31:0] m_regs [NR];
  logic [31:0] m_fifo [$];
  bit          m_ovf = 1'b0;
  logic [31:0] m_cycles = '0;

  // Mailbox word number for a byte address, or -1 when outside the window or misaligned.
  function automatic int word_of(input logic [31:0] a);
    if (a[1:0] != 2'b00 || a < BASE || a >= BASE + 32'(4 * NR)) return -1;
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int w;
    w = word_of(a);
    return (w >= 0) ? m_regs[w] : 32'd0;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    int  ci, ei, nxt;
    bit  done_now;
    if (reset !== 1'b1) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_fifo.delete();
      m_ovf    = 1'b0;
      m_state  = 0;
      m_cycles = '0;
      return;
    end
    ci = word_of(DataAdr);
    ei = word_of(Ext_DataAdr);
    done_now = 1'b0;
    if (m_state <= 1 && !cpu_run && Ext_MemWrite && ei >= 0) m_regs[ei] = Ext_WriteData;
    if (m_state == 2 && MemWrite && ci >= 0) begin
      m_regs[ci] = WriteData;
      if (ci == DIDX && WriteData != 0) done_now = 1'b1;
    end
    if (stream_ready && m_fifo.size() > 0) void'(m_fifo.pop_front());
    if (m_state == 2 && MemWrite && ci == SIDX) begin
      if (m_fifo.size() < FD) m_fifo.push_back(WriteData);
      else m_ovf = 1'b1;
    end
    case (m_state)
      0:       nxt = cpu_run ? 2 : (Ext_MemWrite ? 1 : 0);
      1:       nxt = cpu_run ? 2 : 1;
      2:       nxt = done_now ? 3 : 2;
      default: nxt = cpu_run ? 3 : 0;
    endcase
    if (m_state <= 1 && nxt == 2) m_cycles = '0;
    else if (m_state == 2 && m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
    m_state = nxt;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [31:0] a, input logic [31:0] d);
    Ext_DataAdr = a; Ext_WriteData = d; Ext_MemWrite = 1'b1;
    step();
    Ext_MemWrite = 1'b0;
  endtask

  task automatic cpu_store(input logic [31:0] a, input logic [31:0] d);
    DataAdr = a; WriteData = d; MemWrite = 1'b1;
    step();
    MemWrite = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    n_checks++; if (mb_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", mb_state); end
    n_checks++; if (stream_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", stream_valid); end
    n_checks++; if (cpu_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", cpu_done); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    n_checks++; if (run_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_cycles: got %0d want 0", run_cycles); end
    for (int i = 0; i < NR; i++) begin
      DataAdr = BASE + 32'(4 * i);
      #1;
      n_checks++; if (mb_hit !== 1'b1 || mb_rdata !== 32'd0) begin
        n_fail++; $display("FAIL reset_word%0d: got hit=%b data=%h want hit=1 data=0", i, mb_hit, mb_rdata);
      end
    end
  endtask

  task automatic test_idle_store();
    cpu_store(BASE, $urandom | 32'h1);
    DataAdr = BASE;
    #1;
    n_checks++; if (mb_rdata !== 32'd0) begin n_fail++; $display("FAIL idle_store_ignored: got %h want 0", mb_rdata); end
    n_checks++; if (mb_state !== 2'd0) begin n_fail++; $display("FAIL idle_store_state: got %0d want 0", mb_state); end
  endtask

  task automatic test_preload();
    host_write(BASE, 32'd20);
    n_checks++; if (mb_state !== 2'd1) begin n_fail++; $display("FAIL preload_load_state: got %0d want 1", mb_state); end
    host_write(BASE + 32'd4, 32'd0);
    host_write(BASE + 32'd12, $urandom);
    host_write(BASE + 32'd6, $urandom);
    // Host write on the same edge cpu_run rises must be ignored.
    Ext_DataAdr = BASE; Ext_WriteData = 32'd99; Ext_MemWrite = 1'b1; cpu_run = 1'b1;
    step();
    Ext_MemWrite = 1'b0;
    n_checks++; if (mb_state !== 2'd2) begin n_fail++; $display("FAIL preload_run_state: got %0d want 2", mb_state); end
    DataAdr = BASE;
    #1;
    n_checks++; if (mb_hit !== 1'b1 || mb_rdata !== 32'd20) begin
      n_fail++; $display("FAIL preload_read0: got hit=%b data=%0d want hit=1 data=20", mb_hit, mb_rdata);
    end
    for (int i = 1; i < NR; i++) begin
      DataAdr = BASE + 32'(4 * i);
      #1;
      n_checks++; if (mb_rdata !== m_regs[i]) begin
        n_fail++; $display("FAIL preload_word%0d: got %h want %h", i, mb_rdata, m_regs[i]);
      end
    end
  endtask

  task automatic test_guard();
    host_write(BASE, 32'd7);
    DataAdr = BASE;
    #1;
    n_checks++; if (mb_rdata !== 32'd20) begin n_fail++; $display("FAIL guard_host_in_run: got %0d want 20", mb_rdata); end
    DataAdr = BASE + 32'd2;
    #1;
    n_checks++; if (mb_hit !== 1'b0 || mb_rdata !== 32'd0) begin
      n_fail++; $display("FAIL guard_misaligned: got hit=%b data=%h want hit=0 data=0", mb_hit, mb_rdata);
    end
    DataAdr = BASE + 32'd16;
    #1;
    n_checks++; if (mb_hit !== 1'b0) begin n_fail++; $display("FAIL guard_above: got hit=%b want 0", mb_hit); end
    DataAdr = BASE - 32'd4;
    #1;
    n_checks++; if (mb_hit !== 1'b0) begin n_fail++; $display("FAIL guard_below: got hit=%b want 0", mb_hit); end
  endtask

  task automatic test_stream();
    logic [31:0] exp [4];
    int pops;
    exp = '{32'd1, 32'd3, 32'd6, 32'd10};
    stream_ready = 1'b0;
    // A store is not visible to a load in its own cycle.
    DataAdr = BASE + 32'd8; WriteData = 32'd1; MemWrite = 1'b1;
    #1;
    n_checks++; if (mb_rdata !== 32'd0) begin n_fail++; $display("FAIL stream_same_cycle_read: got %h want 0", mb_rdata); end
    step();
    MemWrite = 1'b0;
    n_checks++; if (stream_valid !== 1'b1 || stream_data !== 32'd1) begin
      n_fail++; $display("FAIL stream_latency: got valid=%b data=%0d want valid=1 data=1", stream_valid, stream_data);
    end
    for (int i = 1; i < 4; i++) cpu_store(BASE + 32'd8, exp[i]);
    cpu_store(BASE + 32'd4, $urandom);
    DataAdr = BASE + 32'd4;
    #1;
    n_checks++; if (mb_rdata !== m_regs[1]) begin n_fail++; $display("FAIL stream_word1: got %h want %h", mb_rdata, m_regs[1]); end
    stream_ready = 1'b1;
    pops = 0;
    for (int c = 0; c < 10 && stream_valid === 1'b1; c++) begin
      n_checks++; if (pops >= 4 || stream_data !== exp[pops]) begin
        n_fail++; $display("FAIL stream_order%0d: got %0d want %0d", pops, stream_data, (pops < 4) ? exp[pops] : 32'd0);
      end
      pops++;
      step();
    end
    n_checks++; if (pops !== 4 || stream_valid !== 1'b0) begin
      n_fail++; $display("FAIL stream_drain: got pops=%0d valid=%b want pops=4 valid=0", pops, stream_valid);
    end
    stream_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] first, last;
    int pops;
    stream_ready = 1'b0;
    first = $urandom;
    cpu_store(BASE + 32'd8, first);
    for (int i = 1; i < FD; i++) cpu_store(BASE + 32'd8, $urandom);
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_at_full: got %b want 0", overflow); end
    cpu_store(BASE + 32'd8, $urandom);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_17th: got %b want 1", overflow); end
    n_checks++; if (stream_data !== first) begin n_fail++; $display("FAIL ovf_head: got %h want %h", stream_data, first); end
    last = $urandom;
    stream_ready = 1'b1;
    cpu_store(BASE + 32'd8, last);
    pops = 0;
    for (int c = 0; c < 40 && stream_valid === 1'b1; c++) begin
      n_checks++; if (m_fifo.size() == 0 || stream_data !== m_fifo[0]) begin
        n_fail++; $display("FAIL ovf_drain%0d: got %h want %h", pops, stream_data, (m_fifo.size() > 0) ? m_fifo[0] : 32'd0);
      end
      if (m_fifo.size() == 1) begin
        n_checks++; if (stream_data !== last) begin n_fail++; $display("FAIL ovf_last: got %h want %h", stream_data, last); end
      end
      pops++;
      step();
    end
    n_checks++; if (pops !== FD) begin n_fail++; $display("FAIL ovf_count: got %0d want %0d", pops, FD); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    stream_ready = 1'b0;
  endtask

  task automatic test_random_traffic();
    logic [31:0] addrs [5];
    int errs;
    addrs = '{BASE, BASE + 32'd4, BASE + 32'd8, BASE + 32'd2, BASE + 32'd16};
    errs = 0;
    for (int c = 0; c < 80; c++) begin
      DataAdr      = addrs[$urandom_range(0, 4)];
      WriteData    = $urandom;
      MemWrite     = 1'($urandom_range(0, 1));
      stream_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_checks++; if (mb_hit !== (word_of(DataAdr) >= 0) || mb_rdata !== m_read(DataAdr)) begin
        n_fail++; $display("FAIL rand_read c%0d: got hit=%b data=%h want data=%h", c, mb_hit, mb_rdata, m_read(DataAdr));
      end
      step();
      n_checks++;
      if (mb_state !== 2'(m_state) || stream_valid !== (m_fifo.size() > 0) || overflow !== m_ovf
          || (m_fifo.size() > 0 && stream_data !== m_fifo[0])) begin
        n_fail++;
        $display("FAIL rand_state c%0d: got st=%0d v=%b d=%h ovf=%b want st=%0d v=%b ovf=%b",
                 c, mb_state, stream_valid, stream_data, overflow, m_state, m_fifo.size() > 0, m_ovf);
      end
    end
    MemWrite = 1'b0;
    stream_ready = 1'b1;
    for (int c = 0; c < FD + 2; c++) step();
    n_checks++; if (stream_valid !== 1'b0) begin n_fail++; $display("FAIL rand_drain: got %b want 0", stream_valid); end
    stream_ready = 1'b0;
  endtask

  task automatic test_done();
    cpu_store(BASE + 32'd12, 32'd1);
    n_checks++; if (cpu_done !== 1'b1 || mb_state !== 2'd3) begin
      n_fail++; $display("FAIL done_enter: got done=%b st=%0d want done=1 st=3", cpu_done, mb_state);
    end
    n_checks++; if (run_cycles !== (CNT_EN ? m_cycles : 32'd0)) begin
      n_fail++; $display("FAIL done_cycles1: got %0d want %0d", run_cycles, CNT_EN ? m_cycles : 32'd0);
    end
    cpu_store(BASE, $urandom);
    DataAdr = BASE;
    #1;
    n_checks++; if (mb_rdata !== m_regs[0]) begin n_fail++; $display("FAIL done_store_ignored: got %h want %h", mb_rdata, m_regs[0]); end
    cpu_run = 1'b0;
    step();
    n_checks++; if (cpu_done !== 1'b0 || mb_state !== 2'd0) begin
      n_fail++; $display("FAIL done_leave: got done=%b st=%0d want done=0 st=0", cpu_done, mb_state);
    end
    // Second run: exactly 50 cycles in RUN, including two stream stores and the final done store.
    cpu_run = 1'b1;
    stream_ready = 1'b0;
    step();
    cpu_store(BASE + 32'd12, 32'd0);
    n_checks++; if (mb_state !== 2'd2 || cpu_done !== 1'b0) begin
      n_fail++; $display("FAIL done_zero_store: got st=%0d done=%b want st=2 done=0", mb_state, cpu_done);
    end
    cpu_store(BASE + 32'd8, 32'hA5A5_0001);
    cpu_store(BASE + 32'd8, 32'hA5A5_0002);
    for (int i = 0; i < 46; i++) step();
    cpu_store(BASE + 32'd12, 32'd5);
    n_checks++; if (mb_state !== 2'd3) begin n_fail++; $display("FAIL done_second: got st=%0d want 3", mb_state); end
    n_checks++; if (run_cycles !== (CNT_EN ? 32'd50 : 32'd0)) begin
      n_fail++; $display("FAIL done_cycles50: got %0d want %0d", run_cycles, CNT_EN ? 50 : 0);
    end
    stream_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (stream_valid !== 1'b1 || stream_data !== m_fifo[0]) begin
        n_fail++; $display("FAIL done_drain%0d: got v=%b d=%h want v=1 d=%h", i, stream_valid, stream_data, m_fifo[0]);
      end
      step();
    end
    n_checks++; if (stream_valid !== 1'b0) begin n_fail++; $display("FAIL done_drained: got %b want 0", stream_valid); end
    n_checks++; if (run_cycles !== (CNT_EN ? 32'd50 : 32'd0)) begin
      n_fail++; $display("FAIL done_cycles_hold: got %0d want %0d", run_cycles, CNT_EN ? 50 : 0);
    end
    stream_ready = 1'b0;
    cpu_run = 1'b0;
    step();
    n_checks++; if (mb_state !== 2'd0) begin n_fail++; $display("FAIL done_idle: got %0d want 0", mb_state); end
  endtask

  task automatic test_reset_mid_run();
    cpu_run = 1'b1;
    stream_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) cpu_store(BASE + 32'd8, $urandom);
    cpu_store(BASE + 32'd4, $urandom | 32'h1);
    n_checks++; if (stream_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %b want 1", stream_valid); end
    reset = 1'b0;
    cpu_run = 1'b0;
    step();
    reset = 1'b1;
    n_checks++; if (stream_valid !== 1'b0 || mb_state !== 2'd0 || overflow !== 1'b0 || cpu_done !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_run: got v=%b st=%0d ovf=%b done=%b want 0 0 0 0", stream_valid, mb_state, overflow, cpu_done);
    end
    for (int i = 0; i < NR; i++) begin
      DataAdr = BASE + 32'(4 * i);
      #1;
      n_checks++; if (mb_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_word%0d: got %h want 0", i, mb_rdata); end
    end
  endtask

  initial begin
    reset = 1'b0; cpu_run = 1'b0; Ext_MemWrite = 1'b0; MemWrite = 1'b0; stream_ready = 1'b0;
    Ext_DataAdr = '0; Ext_WriteData = '0; DataAdr = '0; WriteData = '0;
    foreach (m_regs[i]) m_regs[i] = '0;
    test_reset();
    test_idle_store();
    test_preload();
    test_guard();
    test_stream();
    test_overflow();
    test_random_traffic();
    test_done();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
